// File: rtl/fpc_seq_if.sv
// Handshake bundle between a sample source, the fpc_seq converter and its consumer.
// Input side: in_valid/in_ready/D (two's-complement sample, IN_W = MAN_W + 2**EXP_W bits).
// Output side: out_valid/out_ready qualify S/E/F/sat/rnd_up; slave = converter view, master = driver view.
interface fpc_seq_if #(
    parameter int EXP_W = 3,
    parameter int MAN_W = 4
);
    localparam int IN_W = MAN_W + 2**EXP_W;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  D;
    logic             out_valid;
    logic             out_ready;
    logic             S;
    logic [EXP_W-1:0] E;
    logic [MAN_W-1:0] F;
    logic             sat;
    logic             rnd_up;

    modport master (
        output in_valid, D, out_ready,
        input  in_ready, out_valid, S, E, F, sat, rnd_up
    );

    modport slave (
        input  in_valid, D, out_ready,
        output in_ready, out_valid, S, E, F, sat, rnd_up
    );
endinterface

// File: rtl/fpc_seq.sv
// Two's-complement to sign/exponent/significand converter, normalising one bit per clock.
// Latency: result valid s+2 edges after the accepting edge (s = shifts, 0..E_MAX).
// Backpressure: one sample in flight; in_ready low until the result is taken via out_ready.
// Ports: clk, rst (synchronous, active-high), bus (fpc_seq_if.slave: in_valid/in_ready/D,
//        out_valid/out_ready/S/E/F/sat/rnd_up). All outputs are registered.
module fpc_seq #(
    parameter int EXP_W = 3,
    parameter int MAN_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    fpc_seq_if.slave    bus
);
    localparam int IN_W  = MAN_W + 2**EXP_W;
    localparam int MAG_W = IN_W - 1;
    localparam int E_MAX = 2**EXP_W - 1;
    // Position of the first dropped bit once the magnitude is normalised.
    localparam int R_POS = IN_W - 2 - MAN_W;
    localparam logic [EXP_W-1:0] E_MAX_V = EXP_W'(E_MAX);
    localparam logic [MAN_W-1:0] F_MSB   = MAN_W'(1) << (MAN_W - 1);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t           state_q;
    logic [MAG_W-1:0] mag_q;
    logic [EXP_W-1:0] ecnt_q;
    logic             sign_q;
    logic             sat_in_q;

    logic             in_ready_q;
    logic             out_valid_q;
    logic             s_q;
    logic [EXP_W-1:0] e_q;
    logic [MAN_W-1:0] f_q;
    logic             sat_q;
    logic             rnd_up_q;

    // Magnitude of the incoming sample.
    logic             is_min_d;
    logic [MAG_W-1:0] neg_low_d;
    logic [MAG_W-1:0] mag_d;

    always_comb begin
        is_min_d  = bus.D[IN_W-1] && (bus.D[MAG_W-1:0] == '0);
        // Any negative value other than the minimum has |D| below 2**MAG_W,
        // so the low bits of the two's-complement negation are the whole magnitude.
        neg_low_d = ~bus.D[MAG_W-1:0] + MAG_W'(1);
        if (is_min_d) begin
            mag_d = '1;
        end else if (bus.D[IN_W-1]) begin
            mag_d = neg_low_d;
        end else begin
            mag_d = bus.D[MAG_W-1:0];
        end
    end

    // Round-to-nearest on the first dropped bit of the normalised magnitude.
    logic [MAN_W-1:0] f_cur_d;
    logic             r_bit_d;
    logic [MAN_W-1:0] f_d;
    logic [EXP_W-1:0] e_d;
    logic             sat_rnd_d;
    logic             rnd_up_d;

    always_comb begin
        f_cur_d   = mag_q[IN_W-2 -: MAN_W];
        r_bit_d   = mag_q[R_POS];
        f_d       = f_cur_d;
        e_d       = ecnt_q;
        sat_rnd_d = 1'b0;
        rnd_up_d  = 1'b0;
        if (r_bit_d) begin
            if (!(&f_cur_d)) begin
                f_d      = f_cur_d + MAN_W'(1);
                rnd_up_d = 1'b1;
            end else if (ecnt_q != E_MAX_V) begin
                // Significand carry-out: renormalise by bumping the exponent.
                f_d      = F_MSB;
                e_d      = ecnt_q + EXP_W'(1);
                rnd_up_d = 1'b1;
            end else begin
                // No exponent headroom left: clamp to the largest code.
                sat_rnd_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mag_q       <= '0;
            ecnt_q      <= '0;
            sign_q      <= 1'b0;
            sat_in_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            s_q         <= 1'b0;
            e_q         <= '0;
            f_q         <= '0;
            sat_q       <= 1'b0;
            rnd_up_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign_q     <= bus.D[IN_W-1];
                        mag_q      <= mag_d;
                        sat_in_q   <= is_min_d;
                        ecnt_q     <= E_MAX_V;
                        in_ready_q <= 1'b0;
                        state_q    <= NORM;
                    end
                end
                NORM: begin
                    // Stop at a leading one or when the exponent bottoms out (denormal).
                    if (ecnt_q != '0 && !mag_q[IN_W-2]) begin
                        mag_q  <= {mag_q[MAG_W-2:0], 1'b0};
                        ecnt_q <= ecnt_q - EXP_W'(1);
                    end else begin
                        state_q <= ROUND;
                    end
                end
                ROUND: begin
                    s_q         <= sign_q;
                    e_q         <= e_d;
                    f_q         <= f_d;
                    sat_q       <= sat_in_q | sat_rnd_d;
                    rnd_up_q    <= rnd_up_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.S         = s_q;
    assign bus.E         = e_q;
    assign bus.F         = f_q;
    assign bus.sat       = sat_q;
    assign bus.rnd_up    = rnd_up_q;
endmodule

// File: tb/tb_fpc_seq.sv
// Bench for fpc_seq: default widths (EXP_W=3, MAN_W=4) plus a second instance at EXP_W=2, MAN_W=5.
// Expected results come from a value-level reference model and a directed table; a monitor
// pops them as results appear, also checking latency, hold stability and in_ready exclusion.
module tb_fpc_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpc_seq_if #(.EXP_W(3), .MAN_W(4)) bus_a ();
    fpc_seq_if #(.EXP_W(2), .MAN_W(5)) bus_b ();

    fpc_seq #(.EXP_W(3), .MAN_W(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    fpc_seq #(.EXP_W(2), .MAN_W(5)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    assign bus_b.out_ready = 1'b1;

    typedef struct {
        int sg;
        int s;
        int e;
        int f;
        int sat;
        int rnd;
        int acc;
        bit hold;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   outs_a = 0;
    bit   pres_a = 0;
    int   stall_a = 0;
    exp_t cur_a;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic exp_t mk(input int sg, input int s, input int e, input int f,
                                input int sat, input int rnd, input bit hold);
        exp_t x;
        x = '{default: 0};
        x.sg = sg; x.s = s; x.e = e; x.f = f; x.sat = sat; x.rnd = rnd; x.hold = hold;
        return x;
    endfunction

    // Reference: find the leading one arithmetically, scale, then round on value.
    function automatic exp_t model(input longint d, input int ew, input int mw);
        exp_t   x;
        int     in_w, emax, p;
        longint half, v, mag, sc, f, r;
        x    = '{default: 0};
        in_w = mw + (1 << ew);
        emax = (1 << ew) - 1;
        half = longint'(1) << (in_w - 1);
        v    = (d >= half) ? d - 2 * half : d;
        x.sg = (v < 0) ? 1 : 0;
        mag  = (v < 0) ? -v : v;
        if (mag > half - 1) begin
            mag   = half - 1;
            x.sat = 1;
        end
        if (mag == 0) begin
            x.s = emax;
            return x;
        end
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        x.s = (in_w - 2 - p < emax) ? in_w - 2 - p : emax;
        x.e = emax - x.s;
        sc  = mag << x.s;
        f   = sc >> (in_w - 1 - mw);
        r   = (sc >> (in_w - 2 - mw)) & 1;
        if (r == 1) begin
            if (f < (longint'(1) << mw) - 1) begin
                f++;
                x.rnd = 1;
            end else if (x.e < emax) begin
                f = longint'(1) << (mw - 1);
                x.e++;
                x.rnd = 1;
            end else begin
                x.sat = 1;
            end
        end
        x.f = int'(f);
        return x;
    endfunction

    function automatic longint pack_a(input exp_t x);
        return longint'((x.sg << 9) | (x.e << 6) | (x.f << 2) | (x.sat << 1) | x.rnd);
    endfunction

    // Monitor for the default-width instance, with randomised consumer backpressure.
    always @(negedge clk) begin
        if (rst) begin
            pres_a = 0;
            stall_a = 0;
            bus_a.out_ready = 1'b0;
        end else if (bus_a.out_valid) begin
            chk("a_in_ready_while_valid", bus_a.in_ready, 0);
            if (!pres_a) begin
                if (qa.size() == 0) begin
                    chk("a_output_without_sample", bus_a.out_valid, 0);
                end else begin
                    cur_a = qa.pop_front();
                    pres_a = 1;
                    outs_a++;
                    chk("a_S", bus_a.S, cur_a.sg);
                    chk("a_E", bus_a.E, cur_a.e);
                    chk("a_F", bus_a.F, cur_a.f);
                    chk("a_sat", bus_a.sat, cur_a.sat);
                    chk("a_rnd_up", bus_a.rnd_up, cur_a.rnd);
                    chk("a_latency", cyc - cur_a.acc, cur_a.s + 2);
                    if (cur_a.hold) stall_a = 5;
                end
            end else begin
                chk("a_stable", {bus_a.S, bus_a.E, bus_a.F, bus_a.sat, bus_a.rnd_up}, pack_a(cur_a));
            end
            if (stall_a > 0) begin
                bus_a.out_ready = 1'b0;
                stall_a--;
            end else begin
                bus_a.out_ready = ($urandom_range(0, 3) != 0);
            end
            if (bus_a.out_ready) pres_a = 0;
        end else begin
            bus_a.out_ready = ($urandom_range(0, 1) == 1);
            pres_a = 0;
        end
    end

    // Monitor for the narrow-exponent instance; consumer always ready.
    always @(negedge clk) begin
        exp_t x;
        if (!rst && bus_b.out_valid) begin
            if (qb.size() == 0) begin
                chk("b_output_without_sample", bus_b.out_valid, 0);
            end else begin
                x = qb.pop_front();
                chk("b_S", bus_b.S, x.sg);
                chk("b_E", bus_b.E, x.e);
                chk("b_F", bus_b.F, x.f);
                chk("b_sat", bus_b.sat, x.sat);
                chk("b_rnd_up", bus_b.rnd_up, x.rnd);
                chk("b_latency", cyc - x.acc, x.s + 2);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge (or gap).
    task automatic send_a(input logic [11:0] d, input exp_t e);
        bit acc;
        acc = 0;
        bus_a.D = d;
        bus_a.in_valid = 1'b1;
        for (int i = 0; i < 60 && !acc; i++) begin
            acc = bus_a.in_ready;
            @(posedge clk);
            if (!acc) @(negedge clk);
        end
        @(negedge clk);
        if (!acc) begin
            chk("a_accept_timeout", acc, 1);
            bus_a.in_valid = 1'b0;
            return;
        end
        e.acc = cyc;
        qa.push_back(e);
        if ($urandom_range(0, 2) == 0) begin
            bus_a.in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    task automatic send_b(input logic [8:0] d, input exp_t e);
        bit acc;
        acc = 0;
        bus_b.D = d;
        bus_b.in_valid = 1'b1;
        for (int i = 0; i < 60 && !acc; i++) begin
            acc = bus_b.in_ready;
            @(posedge clk);
            if (!acc) @(negedge clk);
        end
        @(negedge clk);
        if (!acc) begin
            chk("b_accept_timeout", acc, 1);
            bus_b.in_valid = 1'b0;
            return;
        end
        e.acc = cyc;
        qb.push_back(e);
    endtask

    task automatic drain_a();
        for (int i = 0; i < 400 && (qa.size() != 0 || pres_a || bus_a.out_valid); i++)
            @(negedge clk);
        chk("a_drain_pending", qa.size(), 0);
    endtask

    task automatic drain_b();
        for (int i = 0; i < 400 && (qb.size() != 0 || bus_b.out_valid); i++)
            @(negedge clk);
        chk("b_drain_pending", qb.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        logic [11:0] da;
        logic [8:0]  db;
        exp_t        e;
        int          outs_before;

        rst = 1'b1;
        bus_a.in_valid = 1'b0;
        bus_a.D = '0;
        bus_b.in_valid = 1'b0;
        bus_b.D = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_in_ready", bus_a.in_ready, 1);
        chk("rst_a_out_valid", bus_a.out_valid, 0);
        chk("rst_a_outputs", {bus_a.S, bus_a.E, bus_a.F, bus_a.sat, bus_a.rnd_up}, 0);
        chk("rst_b_in_ready", bus_b.in_ready, 1);
        chk("rst_b_out_valid", bus_b.out_valid, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases at default widths.
        send_a(12'd45,   mk(0, 5, 2, 11, 0, 0, 0));
        send_a(12'd47,   mk(0, 5, 2, 12, 0, 1, 1));
        send_a(12'd125,  mk(0, 4, 4, 8,  0, 1, 0));
        send_a(12'd2047, mk(0, 0, 7, 15, 1, 0, 1));
        send_a(12'h800,  mk(1, 0, 7, 15, 1, 0, 0));
        send_a(12'hFFF,  mk(1, 7, 0, 1,  0, 0, 0));
        send_a(12'h000,  mk(0, 7, 0, 0,  0, 0, 0));

        // Random magnitudes spread across all exponents, both signs.
        for (int n = 0; n < 40; n++) begin
            da = 12'($urandom_range(0, 4095));
            da = da >> $urandom_range(0, 11);
            if ($urandom_range(0, 1) == 1) da = -da;
            e = model(longint'(da), 3, 4);
            e.hold = ($urandom_range(0, 7) == 0);
            send_a(da, e);
        end
        send_a(12'd45, mk(0, 5, 2, 11, 0, 0, 0));
        bus_a.in_valid = 1'b0;
        drain_a();

        // Reset while normalising: sample dropped, outputs cleared, nothing emitted.
        @(negedge clk);
        chk("a_idle_ready", bus_a.in_ready, 1);
        bus_a.D = 12'h000;
        bus_a.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        chk("a_busy_not_ready", bus_a.in_ready, 0);
        outs_before = outs_a;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_in_ready", bus_a.in_ready, 1);
        chk("midrst_out_valid", bus_a.out_valid, 0);
        chk("midrst_outputs", {bus_a.S, bus_a.E, bus_a.F, bus_a.sat, bus_a.rnd_up}, 0);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("midrst_no_stale_result", outs_a, outs_before);
        send_a(12'd47,  mk(0, 5, 2, 12, 0, 1, 0));
        send_a(12'hFFF, mk(1, 7, 0, 1,  0, 0, 0));
        bus_a.in_valid = 1'b0;
        drain_a();

        // Narrow exponent, wide significand.
        send_b(9'h0FF, mk(0, 0, 3, 31, 1, 0, 0));
        send_b(9'h00B, mk(0, 3, 0, 11, 0, 0, 0));
        send_b(9'h100, mk(1, 0, 3, 31, 1, 0, 0));
        for (int n = 0; n < 15; n++) begin
            db = 9'($urandom_range(0, 511));
            db = db >> $urandom_range(0, 8);
            if ($urandom_range(0, 1) == 1) db = -db;
            send_b(db, model(longint'(db), 2, 5));
        end
        bus_b.in_valid = 1'b0;
        drain_b();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
